fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg -- types shared by the instruction fetch unit and its prefetch queue.
//   fetch_state_t : fetch sequencer states (BOOT, RUN, HALT)
//   fetch_entry_t : prefetch queue entry {pc, instr} at the default 32/32 widths.
//                   It is also the default entry type of fetch_fifo.
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam int DEFAULT_PC_WIDTH    = 32;
  localparam int DEFAULT_INSTR_WIDTH = 32;

  typedef struct packed {
    logic [DEFAULT_PC_WIDTH-1:0]    pc;
    logic [DEFAULT_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo -- synchronous prefetch queue with flush.
//   clk, rst (async, active high)
//   flush        : drop every entry (overrides push/pop this cycle)
//   push, wdata  : enqueue; accepted when not full, or when full and popping
//   pop, rdata   : dequeue the head; rdata shows the head whenever !empty
//   full, empty, count : occupancy status
// DEPTH must be a power of two, >= 2.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  output entry_t                 rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_COUNT = DEPTH[AW:0];

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // NOTE: storage carries no reset; an entry is only visible once count says
  // it was written, so clearing the array would buy nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction fetch front end with a small prefetch queue.
//   clk_i, rst_i (async, active high)
//   imemReq_o / imemAddr_o : read request; imemRdata_i returns one cycle later
//   redirect_i / redirectPc_i : control-flow change, flushes everything queued
//   instrValid_o / instrReady_i : head handshake toward decode
//   instr_o, pc_o, pcPlus4_o : head instruction, its PC and PC+4 (0 when empty)
//   fetchErr_o : sticky misaligned-redirect flag
// Build option: define FETCH_MISALIGN_CHECK_EN to halt on a redirect target
// with nonzero low bits; otherwise those bits are cleared and fetch continues.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 32,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  FIFO_DEPTH  = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   imemReq_o,
  output logic [PC_WIDTH-1:0]    imemAddr_o,
  input  logic [INSTR_WIDTH-1:0] imemRdata_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirectPc_i,
  output logic                   instrValid_o,
  input  logic                   instrReady_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic [PC_WIDTH-1:0]    pcPlus4_o,
  output logic                   fetchErr_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  // Same layout as fetch_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  fetch_state_t        state;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] resp_pc;
  logic [PC_WIDTH-1:0] target_pc;
  logic                in_flight;
  logic                misaligned;
  logic                fetch_err;

  logic                q_push;
  logic                q_pop;
  logic                q_empty;
  logic                q_full_unused;
  logic [CNT_W-1:0]    q_count;
  entry_t              q_wdata;
  entry_t              q_head;
  logic [OCC_W-1:0]    occupancy;
  logic [OCC_W-1:0]    limit;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = redirect_i && (redirectPc_i[1:0] != 2'b00);
  assign target_pc  = redirectPc_i;
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirectPc_i[1:0];
  assign misaligned     = 1'b0;
  assign target_pc      = {redirectPc_i[PC_WIDTH-1:2], 2'b00};
`endif

  // Responses land one cycle after their request, so the response arriving
  // in a redirect cycle is exactly the stale one: it is dropped here, and no
  // request is issued in the redirect cycle itself.
  assign q_push  = in_flight && !redirect_i;
  assign q_pop   = instrValid_o && instrReady_i;
  assign q_wdata = '{pc: resp_pc, instr: imemRdata_i};

  // Credit the slot freed by a pop this cycle; without it a two-entry queue
  // could not sustain one instruction per cycle.
  assign occupancy = OCC_W'(q_count) + OCC_W'(in_flight);
  assign limit     = OCC_W'(FIFO_DEPTH) + OCC_W'(q_pop);

  assign imemReq_o  = (state == RUN) && !redirect_i && (occupancy < limit);
  assign imemAddr_o = fetch_pc;

  assign instrValid_o = !q_empty;
  assign instr_o      = instrValid_o ? q_head.instr : '0;
  assign pc_o         = instrValid_o ? q_head.pc : '0;
  assign pcPlus4_o    = instrValid_o ? q_head.pc + PC_WIDTH'(4) : '0;
  assign fetchErr_o   = fetch_err;

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (redirect_i),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .rdata (q_head),
    .full  (q_full_unused),
    .empty (q_empty),
    .count (q_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= BOOT;
      fetch_pc  <= RESET_PC;
      resp_pc   <= '0;
      in_flight <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      in_flight <= imemReq_o;
      if (imemReq_o) begin
        resp_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
      end
      unique case (state)
        BOOT, RUN: begin
          if (misaligned) begin
            state     <= HALT;
            fetch_err <= 1'b1;
          end else begin
            state <= RUN;
            if (redirect_i) fetch_pc <= target_pc;
          end
        end
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- self-checking bench for fetch_unit (32-bit PC/instr, depth 2).
// The reference model is stream-level: after reset or a redirect to T, decode
// must see T, T+4, T+8 ... in order with instr = pc ^ data_xor; requests must
// walk the same sequence; the head appears three cycles after the reset
// release / redirect cycle and then never drops while no redirect occurs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk         = 1'b0;
  logic        rst         = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata   = '0;
  logic        redirect    = 1'b0;
  logic [31:0] redirectPc  = '0;
  logic        instrValid;
  logic        instrReady  = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic        fetchErr;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .FIFO_DEPTH  (2),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .imemReq_o    (imemReq),
    .imemAddr_o   (imemAddr),
    .imemRdata_i  (imemRdata),
    .redirect_i   (redirect),
    .redirectPc_i (redirectPc),
    .instrValid_o (instrValid),
    .instrReady_i (instrReady),
    .instr_o      (instr),
    .pc_o         (pc),
    .pcPlus4_o    (pcPlus4),
    .fetchErr_o   (fetchErr)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] data_xor    = '0;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  int          since;
  logic        halted;
  logic        prev_valid, prev_ready, prev_redir;
  logic [31:0] prev_pc, prev_instr;

  // last sampled outputs, for directed checks
  logic        smp_valid, smp_req, smp_err;
  logic [31:0] smp_pc, smp_instr, smp_pcp4, smp_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] norm(input logic [31:0] t);
    return {t[31:2], 2'b00};
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    instrReady = 1'b0;
    redirect   = 1'b0;
    #1;
    check("rst_async_valid", instrValid, 1'b0);
    @(negedge clk);
    check("rst_req",   imemReq, 1'b0);
    check("rst_valid", instrValid, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_pc4",   pcPlus4, 32'h0);
    check("rst_addr",  imemAddr, RST_PC);
    check("rst_err",   fetchErr, 1'b0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    since      = 0;
    exp_pc     = RST_PC;
    exp_req    = RST_PC;
    halted     = 1'b0;
    prev_valid = 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, answer the request.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        req_s;
    logic [31:0] addr_s, p4, ex_instr;
    instrReady = rdy;
    redirect   = redir;
    redirectPc = tgt;
    @(negedge clk);
    smp_valid = instrValid; smp_req = imemReq; smp_err = fetchErr;
    smp_pc = pc; smp_instr = instr; smp_pcp4 = pcPlus4; smp_addr = imemAddr;
    if (halted) begin
      check("halt_valid", instrValid, 1'b0);
      check("halt_req",   imemReq, 1'b0);
      check("halt_err",   fetchErr, 1'b1);
    end else begin
      check("err_clear", fetchErr, 1'b0);
      if (since >= 3)      check("valid_steady", instrValid, 1'b1);
      else if (since >= 1) check("valid_gap", instrValid, 1'b0);
      if (redir)           check("req_on_redirect", imemReq, 1'b0);
      else if (since == 0) check("req_boot", imemReq, 1'b0);
      else if (since == 1) check("req_first", imemReq, 1'b1);
      if (imemReq) begin
        check("req_addr", imemAddr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (prev_valid && !prev_ready && !prev_redir) begin
        check("hold_valid", instrValid, 1'b1);
        check("hold_pc",    pc, prev_pc);
        check("hold_instr", instr, prev_instr);
      end
      if (instrValid && rdy) begin
        p4       = exp_pc + 32'd4;
        ex_instr = exp_pc ^ data_xor;
        check("pop_pc",    pc, exp_pc);
        check("pop_instr", instr, ex_instr);
        check("pop_pc4",   pcPlus4, p4);
        exp_pc = p4;
      end
    end
    req_s  = imemReq;
    addr_s = imemAddr;
    if (redir && !halted) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (tgt[1:0] != 2'b00) halted = 1'b1;
`endif
      exp_pc  = norm(tgt);
      exp_req = norm(tgt);
      since   = 1;
    end else if (since < 3) begin
      since++;
    end
    prev_valid = instrValid;
    prev_ready = rdy;
    prev_redir = redir;
    prev_pc    = pc;
    prev_instr = instr;
    @(posedge clk);
    #1;
    imemRdata = req_s ? (addr_s ^ data_xor) : $urandom();
  endtask

  initial begin
    #2;
    // Reset release with ready=1: first request one cycle later, 0,4,8 back to back.
    do_reset();
    repeat (3) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    check("boot_head0", {smp_valid, smp_pc}, {1'b1, 32'h0});
    cycle(1'b1, 1'b0, '0);
    check("boot_head1", {smp_valid, smp_pc}, {1'b1, 32'h4});
    cycle(1'b1, 1'b0, '0);
    check("boot_head2", {smp_valid, smp_pc}, {1'b1, 32'h8});
    repeat (3) cycle(1'b1, 1'b0, '0);

    // Decode stalled: queue fills to two, requests stop, head stays at 0.
    do_reset();
    repeat (5) cycle(1'b0, 1'b0, '0);
    check("stall_valid", smp_valid, 1'b1);
    check("stall_req",   smp_req, 1'b0);
    check("stall_head",  smp_pc, 32'h0);
    repeat (6) cycle(1'b1, 1'b0, '0);

    // Reset with the queue full: valid drops at once, restart from RESET_PC.
    repeat (4) cycle(1'b0, 1'b0, '0);
    check("full_before_rst", {smp_valid, smp_req}, {1'b1, 1'b0});
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, '0);
    check("post_rst_head", {smp_valid, smp_pc}, {1'b1, RST_PC});

    // Redirect to 0x100 while the request for 0x8 is outstanding.
    data_xor = 32'hC0DE_0000;
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, '0);
    check("inflight_req", {smp_req, smp_addr}, {1'b1, 32'h8});
    cycle(1'b1, 1'b1, 32'h100);
    check("redir_pop_head", smp_pc, 32'h4);
    cycle(1'b1, 1'b0, '0);
    check("redir_first_req", {smp_req, smp_addr}, {1'b1, 32'h100});
    repeat (2) cycle(1'b1, 1'b0, '0);
    check("redir_head_pc",  {smp_valid, smp_pc}, {1'b1, 32'h100});
    check("redir_head_pc4", smp_pcp4, 32'h104);
    repeat (3) cycle(1'b1, 1'b0, '0);

    // Fetch address wraps past the top of the address space.
    cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (3) cycle(1'b1, 1'b0, '0);
    check("wrap_addr", {smp_req, smp_addr}, {1'b1, 32'h0});
    repeat (4) cycle(1'b1, 1'b0, '0);

    // Back-to-back redirects: the second one wins.
    cycle(1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 32'h300);
    repeat (3) cycle(1'b1, 1'b0, '0);
    check("b2b_head", {smp_valid, smp_pc}, {1'b1, 32'h300});
    repeat (2) cycle(1'b0, 1'b0, '0);

    // Misaligned redirect target.
    cycle(1'b1, 1'b1, 32'h0000_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    cycle(1'b1, 1'b0, '0);
    check("misalign_err",  smp_err, 1'b1);
    check("misalign_req",  smp_req, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h400);
    repeat (3) cycle(1'b1, 1'b0, '0);
    check("halt_ignores_redirect", smp_valid, 1'b0);
    do_reset();
`else
    cycle(1'b1, 1'b0, '0);
    check("misalign_forced", {smp_req, smp_addr}, {1'b1, 32'h100});
    repeat (4) cycle(1'b1, 1'b0, '0);
    check("misalign_no_err", smp_err, 1'b0);
`endif

    // Randomized ready/redirect traffic against the stream model.
    data_xor = 32'h5A5A_3C3C;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic        r, d;
      logic [31:0] t;
      if ($urandom_range(0, 149) == 0) do_reset();
      r = ($urandom_range(0, 9) < 7);
      d = ($urandom_range(0, 15) == 0);
      t = $urandom();
`ifdef FETCH_MISALIGN_CHECK_EN
      t[1:0] = 2'b00;
`endif
      cycle(r, d, t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
